verification: RTL and testbench



---
 rtl/verification.sv | 72 +++++++
 tb/tb_verification.sv | 133 +++++++++++++
 2 files changed

// File: rtl/verification.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | verification: free-running up-counter with tc, wrap pulse and Gray out.  |
// | Optional saturating wrap counter enabled by VERIFICATION_WRAP_CNT_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module verification #(
   parameter int WIDTH      = 4,
   parameter int WRAP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [WIDTH-1:0]      counter,
   output logic                  tc,
   output logic                  wrap,
   output logic [WIDTH-1:0]      gray,
   output logic [WRAP_CNT_W-1:0] wrap_count
);

   localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;
   logic [WIDTH-1:0] w_next;
   logic             w_at_max;

   assign w_next   = r_count + C_ONE;
   assign w_at_max = (r_count == C_MAX);

   // Gray is computed from the next count so it lands in the same cycle as counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_gray  <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_next;
         r_gray  <= w_next ^ (w_next >> 1);
         r_wrap  <= w_at_max;
      end
   end

   assign counter = r_count;
   assign gray    = r_gray;
   assign wrap    = r_wrap;
   assign tc      = w_at_max;

`ifdef VERIFICATION_WRAP_CNT_EN
   localparam logic [WRAP_CNT_W-1:0] C_WC_MAX = {WRAP_CNT_W{1'b1}};
   localparam logic [WRAP_CNT_W-1:0] C_WC_ONE = {{(WRAP_CNT_W-1){1'b0}}, 1'b1};

   logic [WRAP_CNT_W-1:0] r_wrap_count;

   // Updates on the same edge that raises wrap; holds at full scale.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrap_count <= '0;
      end else if (w_at_max && (r_wrap_count != C_WC_MAX)) begin
         r_wrap_count <= r_wrap_count + C_WC_ONE;
      end
   end

   assign wrap_count = r_wrap_count;
`else
   assign wrap_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_verification.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for verification: WIDTH=4 (WRAP_CNT_W=2) and WIDTH=2 instances.
module tb_verification;

   logic       clk;
   logic       reset;
   logic [3:0] a_counter, a_gray;
   logic       a_tc, a_wrap;
   logic [1:0] a_wc;
   logic [1:0] b_counter, b_gray;
   logic       b_tc, b_wrap;
   logic [7:0] b_wc;

   int n_pass  = 0;
   int n_total = 0;

   verification #(.WIDTH(4), .WRAP_CNT_W(2)) dut_a (
      .clk(clk), .reset(reset), .counter(a_counter), .tc(a_tc),
      .wrap(a_wrap), .gray(a_gray), .wrap_count(a_wc)
   );

   verification #(.WIDTH(2), .WRAP_CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .counter(b_counter), .tc(b_tc),
      .wrap(b_wrap), .gray(b_gray), .wrap_count(b_wc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a_cnt"},  32'(a_counter), 32'd0);
      chk({tag, "_a_gray"}, 32'(a_gray),    32'd0);
      chk({tag, "_a_tc"},   32'(a_tc),      32'd0);
      chk({tag, "_a_wrap"}, 32'(a_wrap),    32'd0);
      chk({tag, "_a_wc"},   32'(a_wc),      32'd0);
      chk({tag, "_b_cnt"},  32'(b_counter), 32'd0);
      chk({tag, "_b_wc"},   32'(b_wc),      32'd0);
   endtask

   initial begin
      int exp_a, exp_b, prev_a, prev_b, exp_wc;
      logic [3:0] prev_gray;

      reset = 1'b1;
      #2;
      chk_all_zero("rst_async");

      // Held in reset across two edges
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all_zero("rst_held");

      #4 reset = 1'b0;   // t=20, between edges

      exp_a = 0; exp_b = 0; exp_wc = 0;
      prev_gray = 4'd0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         prev_a = exp_a;
         prev_b = exp_b;
         exp_a  = (exp_a + 1) % 16;
         exp_b  = (exp_b + 1) % 4;
         if (prev_a == 15 && exp_wc < 3) exp_wc++;

         chk("a_cnt",  32'(a_counter), 32'(exp_a));
         chk("a_tc",   32'(a_tc),      (exp_a == 15) ? 32'd1 : 32'd0);
         chk("a_wrap", 32'(a_wrap),    (prev_a == 15) ? 32'd1 : 32'd0);
         chk("a_gray", 32'(a_gray),    32'(exp_a ^ (exp_a >> 1)));
         chk("a_gray_1bit", 32'($countones(a_gray ^ prev_gray)), 32'd1);
`ifdef VERIFICATION_WRAP_CNT_EN
         chk("a_wc",   32'(a_wc),      32'(exp_wc));
`else
         chk("a_wc",   32'(a_wc),      32'd0);
`endif
         chk("b_cnt",  32'(b_counter), 32'(exp_b));
         chk("b_tc",   32'(b_tc),      (exp_b == 3) ? 32'd1 : 32'd0);
         chk("b_wrap", 32'(b_wrap),    (prev_b == 3) ? 32'd1 : 32'd0);
         chk("b_gray", 32'(b_gray),    32'(exp_b ^ (exp_b >> 1)));
         prev_gray = a_gray;

         // Hand-computed anchor points on the timeline
         if (i == 1)  chk("t26_cnt1",  32'(a_counter), 32'd1);
         if (i == 2)  chk("t36_cnt2",  32'(a_counter), 32'd2);
         if (i == 5)  chk("cnt5_gray7", 32'(a_gray),   32'd7);
         if (i == 15) begin
            chk("t166_cnt15",  32'(a_counter), 32'd15);
            chk("t166_tc",     32'(a_tc),      32'd1);
            chk("cnt15_gray8", 32'(a_gray),    32'd8);
         end
         if (i == 16) begin
            chk("t176_cnt0", 32'(a_counter), 32'd0);
            chk("t176_wrap", 32'(a_wrap),    32'd1);
            chk("t176_tc",   32'(a_tc),      32'd0);
         end
         if (i == 17) chk("t186_wrap_gone", 32'(a_wrap), 32'd0);
      end

      // Counter is 4 after 100 edges; advance to 9
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_cnt9", 32'(a_counter), 32'd9);

      #2 reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk); #1;
      chk_all_zero("rst_mid_held");
      #3 reset = 1'b0;
      @(posedge clk); #1;
      chk("resume_cnt1", 32'(a_counter), 32'd1);
      chk("resume_b1",   32'(b_counter), 32'd1);
      chk("resume_wc",   32'(a_wc),      32'd0);
      @(posedge clk); #1;
      chk("resume_cnt2", 32'(a_counter), 32'd2);
      chk("resume_gray3", 32'(a_gray),   32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
